// File: rtl/regfile_pkg.sv
// Shared register-file geometry for the RV32E write-back path.
package regfile_pkg;

   localparam int unsigned REG_AW = 4;
   localparam int unsigned NREG   = 16;
   localparam int unsigned XLEN   = 32;
   localparam logic [REG_AW-1:0] REG_ZERO = 4'h0;

endpackage : regfile_pkg

// File: rtl/regfile_wb_sched_arb.sv
// Round-robin arbiter: search starts at the pointer, first requester wins,
// pointer moves one past the winner on every grant.
module rr_arbiter #(
   parameter int unsigned N = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;

   always_comb begin
      int unsigned idx;
      logic [PW-1:0] idx_p;
      logic found;
      gnt   = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      idx   = 0;
      idx_p = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = 32'(ptr_q) + k;
         if (idx >= N) idx = idx - N;
         idx_p = PW'(idx);
         if (!found && req[idx_p]) begin
            found      = 1'b1;
            gnt[idx_p] = 1'b1;
            ptr_d      = (idx == N - 1) ? '0 : PW'(idx + 1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule : rr_arbiter

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and scoreboard: arbitrates write-back sources onto the
// single register-file write port and stalls issue on RAW/WAW hazards.
module regfile_wb_sched
   import regfile_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned AW   = REG_AW,
   parameter int unsigned DW   = XLEN
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 issue_valid,
   input  logic [AW-1:0]        issue_rs1,
   input  logic [AW-1:0]        issue_rs2,
   input  logic [AW-1:0]        issue_rd,
   input  logic                 issue_rd_wen,
   output logic                 issue_ready,
   input  logic [NREQ-1:0]      wb_valid,
   input  logic [NREQ*AW-1:0]   wb_addr,
   input  logic [NREQ*DW-1:0]   wb_data,
   output logic [NREQ-1:0]      wb_ready,
   output logic                 rf_wen,
   output logic [AW-1:0]        rf_waddr,
   output logic [DW-1:0]        rf_wdata,
   output logic [(1<<AW)-1:0]   busy,
   output logic                 wb_err
);

   localparam int unsigned NB = 1 << AW;

   logic [NB-1:0] busy_q, busy_d;
   logic          rf_wen_q, rf_wen_d;
   logic [AW-1:0] rf_waddr_q, rf_waddr_d;
   logic [DW-1:0] rf_wdata_q, rf_wdata_d;
   logic          wb_err_q, wb_err_d;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_data;
   logic          any_gnt;
   logic          set_en;

   rr_arbiter #(.N(NREQ)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (wb_valid),
      .gnt   (wb_ready)
   );

   assign issue_ready = !(busy_q[issue_rs1] | busy_q[issue_rs2] |
                          (issue_rd_wen & busy_q[issue_rd]));
   assign set_en      = issue_valid & issue_ready & issue_rd_wen &
                        (issue_rd != AW'(REG_ZERO));
   assign any_gnt     = |wb_ready;

   // Mux the granted requester's payload onto the write port.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (wb_ready[i]) begin
            sel_addr = wb_addr[i*AW +: AW];
            sel_data = wb_data[i*DW +: DW];
         end
      end
   end

   always_comb begin
      busy_d     = busy_q;
      rf_wen_d   = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      wb_err_d   = wb_err_q;
      // Clear from the write committing this cycle, set from the new issue.
      if (rf_wen_q) busy_d[rf_waddr_q] = 1'b0;
      if (set_en)   busy_d[issue_rd]   = 1'b1;
      if (any_gnt && (sel_addr != AW'(REG_ZERO))) begin
         rf_wen_d   = 1'b1;
         rf_waddr_d = sel_addr;
         rf_wdata_d = sel_data;
         if (!busy_q[sel_addr]) wb_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q     <= '0;
         rf_wen_q   <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         wb_err_q   <= 1'b0;
      end else begin
         assert (!(set_en && rf_wen_q && (issue_rd == rf_waddr_q)));
         busy_q     <= busy_d;
         rf_wen_q   <= rf_wen_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         wb_err_q   <= wb_err_d;
      end
   end

   assign busy     = busy_q;
   assign rf_wen   = rf_wen_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign wb_err   = wb_err_q;

endmodule : regfile_wb_sched

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed scenarios with literal expectations plus
// a per-cycle comparison against a behavioural scoreboard model.
module tb_regfile_wb_sched;

   localparam int NREQ = 2;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                issue_valid = 1'b0;
   logic [3:0]          issue_rs1 = '0, issue_rs2 = '0, issue_rd = '0;
   logic                issue_rd_wen = 1'b0;
   logic                issue_ready;
   logic [NREQ-1:0]     wb_valid = '0;
   logic [NREQ*4-1:0]   wb_addr = '0;
   logic [NREQ*32-1:0]  wb_data = '0;
   logic [NREQ-1:0]     wb_ready;
   logic                rf_wen;
   logic [3:0]          rf_waddr;
   logic [31:0]         rf_wdata;
   logic [15:0]         busy;
   logic                wb_err;

   int checks = 0;
   int errors = 0;

   regfile_wb_sched #(.NREQ(NREQ), .AW(4), .DW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_rd(issue_rd), .issue_rd_wen(issue_rd_wen), .issue_ready(issue_ready),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .busy(busy), .wb_err(wb_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: pending-register set, one in-flight write, sticky error, RR pointer.
   logic [15:0] m_busy = '0;
   logic        m_wen = 1'b0;
   logic [3:0]  m_waddr = '0;
   logic [31:0] m_wdata = '0;
   logic        m_err = 1'b0;
   int          m_ptr = 0;

   function automatic int m_grant();
      for (int k = 0; k < NREQ; k++) begin
         if (wb_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic m_ready();
      return !(m_busy[issue_rs1] || m_busy[issue_rs2] || (issue_rd_wen && m_busy[issue_rd]));
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      int g;
      logic [15:0] nb;
      logic [3:0] a;
      if (!rst_n) begin
         m_busy <= '0; m_wen <= 1'b0; m_waddr <= '0; m_wdata <= '0; m_err <= 1'b0; m_ptr <= 0;
      end else begin
         g  = m_grant();
         nb = m_busy;
         if (m_wen) nb[m_waddr] = 1'b0;
         if (issue_valid && m_ready() && issue_rd_wen && issue_rd != 4'd0) nb[issue_rd] = 1'b1;
         m_wen <= 1'b0;
         if (g >= 0) begin
            a = wb_addr[g*4 +: 4];
            m_ptr <= (g + 1) % NREQ;
            if (a != 4'd0) begin
               m_wen   <= 1'b1;
               m_waddr <= a;
               m_wdata <= wb_data[g*32 +: 32];
               if (!m_busy[a]) m_err <= 1'b1;
            end
         end
         m_busy <= nb;
      end
   end

   always @(negedge clk) begin : compare
      int g;
      logic [NREQ-1:0] eg;
      if (rst_n) begin
         g  = m_grant();
         eg = (g >= 0) ? NREQ'(1 << g) : '0;
         chk("m_issue_ready", 32'(issue_ready), 32'(m_ready()));
         chk("m_wb_ready", 32'(wb_ready), 32'(eg));
         chk("m_busy", 32'(busy), 32'(m_busy));
         chk("m_rf_wen", 32'(rf_wen), 32'(m_wen));
         chk("m_rf_waddr", 32'(rf_waddr), 32'(m_waddr));
         chk("m_rf_wdata", rf_wdata, m_wdata);
         chk("m_wb_err", 32'(wb_err), 32'(m_err));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_issue(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                            input logic [3:0] rd, input logic wen);
      issue_valid = v; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd; issue_rd_wen = wen;
   endtask

   task automatic set_wb(input int i, input logic v, input logic [3:0] a, input logic [31:0] d);
      wb_valid[i] = v; wb_addr[i*4 +: 4] = a; wb_data[i*32 +: 32] = d;
   endtask

   initial begin
      repeat (2) cyc();
      rst_n = 1'b1;
      // Reset state, all registers free.
      set_issue(1'b0, 4'd5, 4'd9, 4'd3, 1'b1);
      #1 chk("rst_ready", 32'(issue_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wen", 32'(rf_wen), 32'd0);

      // RAW on x5.
      set_issue(1'b1, 4'd1, 4'd2, 4'd5, 1'b1);
      cyc();
      chk("raw_busy", 32'(busy), 32'h0020);
      set_issue(1'b1, 4'd5, 4'd0, 4'd6, 1'b1);
      set_wb(0, 1'b1, 4'd5, 32'hDEADBEEF);
      #1 chk("raw_stall", 32'(issue_ready), 32'd0);
      chk("raw_gnt", 32'(wb_ready), 32'h1);
      cyc();
      set_wb(0, 1'b0, 4'd0, 32'd0);
      #1 chk("raw_wen", 32'(rf_wen), 32'd1);
      chk("raw_waddr", 32'(rf_waddr), 32'd5);
      chk("raw_wdata", rf_wdata, 32'hDEADBEEF);
      chk("raw_stall_t1", 32'(issue_ready), 32'd0);
      cyc();
      chk("raw_ready_t2", 32'(issue_ready), 32'd1);
      chk("raw_wen_t2", 32'(rf_wen), 32'd0);
      set_issue(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);

      // Contention: pointer is at LSU, grant it once to return the pointer to EXU.
      set_wb(1, 1'b1, 4'd0, 32'h1);
      #1 chk("lsu_first", 32'(wb_ready), 32'h2);
      cyc();
      set_wb(0, 1'b1, 4'd0, 32'h2);
      #1 chk("cont0", 32'(wb_ready), 32'h1);
      cyc(); chk("cont1", 32'(wb_ready), 32'h2);
      cyc(); chk("cont2", 32'(wb_ready), 32'h1);
      cyc(); chk("cont3", 32'(wb_ready), 32'h2);
      cyc();
      set_wb(1, 1'b0, 4'd0, 32'd0);
      #1 chk("single0", 32'(wb_ready), 32'h1);
      cyc(); chk("single1", 32'(wb_ready), 32'h1);
      cyc(); chk("single2", 32'(wb_ready), 32'h1);
      cyc();
      set_wb(0, 1'b0, 4'd0, 32'd0);
      #1 chk("x0_wen", 32'(rf_wen), 32'd0);
      chk("x0_err", 32'(wb_err), 32'd0);

      // x0 destination never becomes busy.
      set_issue(1'b1, 4'd0, 4'd0, 4'd0, 1'b1);
      cyc();
      set_issue(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
      #1 chk("x0_busy", 32'(busy), 32'd0);

      // Write-back to a free register: written anyway, error is sticky.
      set_wb(1, 1'b1, 4'd7, 32'h12345678);
      #1 chk("err_gnt", 32'(wb_ready), 32'h2);
      cyc();
      set_wb(1, 1'b0, 4'd0, 32'd0);
      #1 chk("err_wen", 32'(rf_wen), 32'd1);
      chk("err_waddr", 32'(rf_waddr), 32'd7);
      chk("err_wdata", rf_wdata, 32'h12345678);
      chk("err_set", 32'(wb_err), 32'd1);
      cyc(); cyc();
      chk("err_sticky", 32'(wb_err), 32'd1);
      chk("err_hold_waddr", 32'(rf_waddr), 32'd7);

      // WAW on x3, then set x4 on the edge that clears x3.
      set_issue(1'b1, 4'd0, 4'd0, 4'd3, 1'b1);
      cyc();
      chk("waw_busy", 32'(busy), 32'h0008);
      chk("waw_stall", 32'(issue_ready), 32'd0);
      set_wb(0, 1'b1, 4'd3, 32'hA5A5A5A5);
      #1 chk("waw_gnt", 32'(wb_ready), 32'h1);
      cyc();
      set_wb(0, 1'b0, 4'd0, 32'd0);
      set_issue(1'b1, 4'd1, 4'd2, 4'd4, 1'b1);
      #1 chk("conc_ready", 32'(issue_ready), 32'd1);
      cyc();
      set_issue(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
      #1 chk("conc_busy", 32'(busy), 32'h0010);

      // Mid-stream reset with busy = 0x0012 and a write in flight.
      set_issue(1'b1, 4'd0, 4'd0, 4'd1, 1'b1);
      cyc();
      set_issue(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
      #1 chk("pre_rst_busy", 32'(busy), 32'h0012);
      set_wb(0, 1'b1, 4'd1, 32'h11);
      cyc();
      set_wb(0, 1'b0, 4'd0, 32'd0);
      #1 chk("pre_rst_wen", 32'(rf_wen), 32'd1);
      rst_n = 1'b0;
      #1 chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_wen", 32'(rf_wen), 32'd0);
      chk("mid_rst_err", 32'(wb_err), 32'd0);
      chk("mid_rst_waddr", 32'(rf_waddr), 32'd0);
      chk("mid_rst_wdata", rf_wdata, 32'd0);
      cyc();
      rst_n = 1'b1;
      set_issue(1'b0, 4'd1, 4'd4, 4'd4, 1'b1);
      #1 chk("post_rst_ready", 32'(issue_ready), 32'd1);
      set_wb(1, 1'b1, 4'd0, 32'd0);
      #1 chk("post_rst_lsu", 32'(wb_ready), 32'h2);
      cyc();
      set_wb(1, 1'b0, 4'd0, 32'd0);
      repeat (2) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_regfile_wb_sched
